// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default parameters for the pipeline control unit.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_STEP_WAIT = 2'd2,
      ST_STEP_GO   = 2'd3
   } state_t;

   localparam int NSTAGE_DEF     = 5;
   localparam int DEB_CYCLES_DEF = 20000;
   localparam int CNT_W_DEF      = 32;
   localparam int DEB_CYCLES_SIM = 4;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on every debounced rising edge.
module btn_debounce
   import pipe_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic          level_r;
   logic          level_d_r;
   logic          press_r;
   logic [CW-1:0] cnt_r;

   // Two-flop synchroniser for the asynchronous button.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= btn;
         sync2_r <= sync1_r;
      end
   end

   // Level is accepted only after DEB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= '0;
         level_r <= 1'b0;
      end else if (sync2_r != level_r) begin
         if (cnt_r == CNT_LAST) begin
            cnt_r   <= '0;
            level_r <= sync2_r;
         end else begin
            cnt_r   <= cnt_r + CW'(1);
            level_r <= level_r;
         end
      end else begin
         cnt_r   <= '0;
         level_r <= level_r;
      end
   end

   // Registered rising-edge pulse of the debounced level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d_r <= 1'b0;
         press_r   <= 1'b0;
      end else begin
         level_d_r <= level_r;
         press_r   <= level_r & ~level_d_r;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: run/single-step FSM, per-stage stall/flush
// resolution and running-cycle performance counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NSTAGE     = NSTAGE_DEF,
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enter,
   input  logic              mode_step,
   input  logic [NSTAGE-1:0] stall_req,
   input  logic [NSTAGE-1:0] flush_req,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] flush,
   output logic              running,
   output logic [CNT_W-1:0]  cyc_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   state_t            state_r;
   logic              running_r;
   logic              mode_s1_r;
   logic              mode_s2_r;
   logic              press_s;
   logic [CNT_W-1:0]  cyc_cnt_r;
   logic [CNT_W-1:0]  stall_cnt_r;
   logic [NSTAGE-1:0] st_ge_s;
   logic [NSTAGE-1:0] acc_s;
   logic [NSTAGE-1:0] acc_gt_s;
   logic [NSTAGE-1:0] bubble_s;
   logic [NSTAGE-1:0] stall_s;
   logic [NSTAGE-1:0] flush_s;

   btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn   (enter),
      .press (press_s)
   );

   // Synchroniser for the mode switch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_s1_r <= 1'b0;
         mode_s2_r <= 1'b0;
      end else begin
         mode_s1_r <= mode_step;
         mode_s2_r <= mode_s1_r;
      end
   end

   // Run-control FSM; running_r tracks the state it moves into.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         running_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (press_s && mode_s2_r) begin
                  state_r   <= ST_STEP_WAIT;
                  running_r <= 1'b0;
               end else if (press_s) begin
                  state_r   <= ST_RUN;
                  running_r <= 1'b1;
               end else begin
                  state_r   <= ST_IDLE;
                  running_r <= 1'b0;
               end
            end
            ST_RUN: begin
               if (mode_s2_r) begin
                  state_r   <= ST_STEP_WAIT;
                  running_r <= 1'b0;
               end else begin
                  state_r   <= ST_RUN;
                  running_r <= 1'b1;
               end
            end
            ST_STEP_WAIT: begin
               if (press_s && mode_s2_r) begin
                  state_r   <= ST_STEP_GO;
                  running_r <= 1'b1;
               end else if (press_s) begin
                  state_r   <= ST_RUN;
                  running_r <= 1'b1;
               end else begin
                  state_r   <= ST_STEP_WAIT;
                  running_r <= 1'b0;
               end
            end
            ST_STEP_GO: begin
               state_r   <= ST_STEP_WAIT;
               running_r <= 1'b0;
            end
            default: begin
               state_r   <= ST_IDLE;
               running_r <= 1'b0;
            end
         endcase
      end
   end

   // Priority scan: st_ge marks stages at or below the oldest stall,
   // acc_gt marks stages younger than the oldest accepted flush.
   always_comb begin
      logic any_v;
      logic acc_v;
      st_ge_s  = '0;
      acc_gt_s = '0;
      bubble_s = '0;
      any_v    = 1'b0;
      acc_v    = 1'b0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         any_v      = any_v | stall_req[k];
         st_ge_s[k] = any_v;
      end
      acc_s = flush_req & ~st_ge_s;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
         acc_gt_s[k] = acc_v;
         acc_v       = acc_v | acc_s[k];
      end
      for (int k = 1; k < NSTAGE; k++) begin
         bubble_s[k] = st_ge_s[k-1] & ~st_ge_s[k];
      end
   end

   // Hold everything while not running; otherwise flush beats stall.
   always_comb begin
      if (running_r) begin
         stall_s = st_ge_s & ~acc_gt_s;
         flush_s = bubble_s | acc_gt_s;
      end else begin
         stall_s = '1;
         flush_s = '0;
      end
   end

   // Performance counters advance only on running cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt_r   <= '0;
         stall_cnt_r <= '0;
      end else if (running_r) begin
         cyc_cnt_r   <= cyc_cnt_r + CNT_W'(1);
         stall_cnt_r <= stall_cnt_r + CNT_W'(|stall_req);
      end else begin
         cyc_cnt_r   <= cyc_cnt_r;
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall     = stall_s;
   assign flush     = flush_s;
   assign running   = running_r;
   assign cyc_cnt   = cyc_cnt_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with a rule-level reference model.
module tb_pipe_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int N  = 5;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          enter;
   logic          mode_step;
   logic [N-1:0]  stall_req;
   logic [N-1:0]  flush_req;
   logic [N-1:0]  stall;
   logic [N-1:0]  flush;
   logic          running;
   logic [CW-1:0] cyc_cnt;
   logic [CW-1:0] stall_cnt;

   int          n_pass  = 0;
   int          n_total = 0;
   bit          exp_run = 1'b0;
   int unsigned m_cyc   = 0;
   int unsigned m_stall = 0;
   int          n_runobs;
   logic [CW-1:0] c0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .NSTAGE     (N),
      .DEB_CYCLES (DEB_CYCLES_SIM),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enter     (enter),
      .mode_step (mode_step),
      .stall_req (stall_req),
      .flush_req (flush_req),
      .stall     (stall),
      .flush     (flush),
      .running   (running),
      .cyc_cnt   (cyc_cnt),
      .stall_cnt (stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: oldest stall s holds k<=s and bubbles s+1; oldest flush f>s clears k<f.
   task automatic ref_res(input logic [N-1:0] sr, input logic [N-1:0] fr, input bit run,
                          output logic [N-1:0] st, output logic [N-1:0] fl);
      int s;
      int f;
      st = '0;
      fl = '0;
      if (!run) begin
         st = '1;
      end else begin
         s = -1;
         for (int i = 0; i < N; i++) if (sr[i]) s = i;
         for (int k = 0; k <= s; k++) st[k] = 1'b1;
         if (s >= 0 && s + 1 < N) fl[s+1] = 1'b1;
         f = -1;
         for (int i = 0; i < N; i++) if (fr[i] && i > s) f = i;
         for (int k = 0; k < f; k++) begin
            fl[k] = 1'b1;
            st[k] = 1'b0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] es;
      logic [N-1:0] ef;
      ref_res(stall_req, flush_req, exp_run, es, ef);
      chk({tag, "_stall"}, stall, es);
      chk({tag, "_flush"}, flush, ef);
      chk({tag, "_running"}, running, exp_run);
      chk({tag, "_cyc"}, cyc_cnt, m_cyc);
      chk({tag, "_stallcnt"}, stall_cnt, m_stall);
   endtask

   // One clock: model counters see the pre-edge state and requests.
   task automatic step(input logic [N-1:0] sr, input logic [N-1:0] fr, input bit run_after,
                       input string tag);
      @(posedge clk);
      if (exp_run) begin
         m_cyc++;
         if (|stall_req) m_stall++;
      end
      #1;
      exp_run   = run_after;
      stall_req = sr;
      flush_req = fr;
      #1;
      check_all(tag);
   endtask

   // Raise enter and hold: press after edge 7, state change at edge 8.
   task automatic do_press(input bit single);
      bit r;
      enter = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         if (single) r = (n == 8);
         else r = (n >= 8) ? 1'b1 : exp_run;
         step('0, '0, r, "press");
         chk("press_pulse", dut.press_s, (n == 7));
         if (running) n_runobs++;
      end
   endtask

   initial begin
      rst       = 1'b1;
      enter     = 1'b0;
      mode_step = 1'b0;
      stall_req = '0;
      flush_req = '0;
      #12;
      check_all("in_reset");
      step('0, '0, 1'b0, "in_reset2");
      rst = 1'b0;

      // 1: idle ignores requests for 100 cycles
      repeat (100) step(N'($urandom), N'($urandom), 1'b0, "idle");

      // 2: single press while held, then short bounces
      do_press(1'b0);
      repeat (3) begin
         enter = 1'b0;
         repeat (2) begin
            step('0, '0, 1'b1, "bounce_lo");
            chk("bounce_press", dut.press_s, 1'b0);
         end
         enter = 1'b1;
         repeat (6) begin
            step('0, '0, 1'b1, "bounce_hi");
            chk("bounce_press", dut.press_s, 1'b0);
         end
      end
      enter = 1'b0;
      repeat (12) step('0, '0, 1'b1, "release");

      // 3: stall in the middle stage
      repeat (3) step(5'b00100, 5'b00000, 1'b1, "stall2");
      chk("t3_stall", stall, 5'b00111);
      chk("t3_flush", flush, 5'b01000);

      // 4: accepted and ignored flush requests
      step(5'b00010, 5'b01000, 1'b1, "flush_acc");
      chk("t4a_flush", flush, 5'b00111);
      chk("t4a_stall", stall, 5'b00000);
      step(5'b00010, 5'b00001, 1'b1, "flush_ign");
      chk("t4b_flush", flush, 5'b00100);
      chk("t4b_stall", stall, 5'b00011);

      repeat (60) step(N'($urandom) & N'($urandom), N'($urandom) & N'($urandom), 1'b1, "rand");

      // 5: single-step mode, three presses
      mode_step = 1'b1;
      step('0, '0, 1'b1, "mode1");
      step('0, '0, 1'b1, "mode2");
      step('0, '0, 1'b0, "mode3");
      c0       = cyc_cnt;
      n_runobs = 0;
      repeat (3) begin
         do_press(1'b1);
         enter = 1'b0;
         repeat (12) step('0, '0, 1'b0, "step_rel");
      end
      chk("step_cyc_delta", cyc_cnt - c0, 32'd3);
      chk("step_run_cycles", n_runobs, 32'd3);

      // 6: back to RUN, then asynchronous reset mid-cycle
      mode_step = 1'b0;
      do_press(1'b0);
      enter = 1'b0;
      repeat (10) step(N'($urandom), N'($urandom), 1'b1, "run2");
      step(5'b00100, 5'b00000, 1'b1, "pre_rst");
      #3;
      rst = 1'b1;
      #1;
      exp_run = 1'b0;
      m_cyc   = 0;
      m_stall = 0;
      check_all("async_rst");
      chk("rst_state", dut.state_r, ST_IDLE);
      step('0, '0, 1'b0, "rst_hold");
      rst = 1'b0;
      repeat (10) step(N'($urandom), N'($urandom), 1'b0, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the CPU core. It holds the pipeline in reset-stall until the operator presses `enter`, then resolves per-stage stall and flush requests into per-stage `stall`/`flush` controls. It adds a single-step mode, on-chip debounce of the raw button, and cycle/stall performance counters. It sits beside the datapath and drives the enable/clear of every pipeline register bank.

## Interface
- `NSTAGE`, default 5: number of pipeline stages; stage 0 is IF (youngest), stage NSTAGE-1 is oldest.
- `DEB_CYCLES`, default 20000: cycles the synchronised `enter` must stay stable before a level change is accepted; must be ≥1.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `enter` in 1: raw, asynchronous, bouncing push-button.
- `mode_step` in 1: level; 1 selects single-step mode. Synchronised internally.
- `stall_req` in NSTAGE: bit i means stage i cannot advance this cycle.
- `flush_req` in NSTAGE: bit i means stage i redirects the PC, so all younger stages are discarded.
- `stall` out NSTAGE: bit i holds stage i's pipeline register.
- `flush` out NSTAGE: bit i clears stage i's pipeline register to a bubble.
- `running` out 1: high in RUN and STEP_GO.
- `cyc_cnt` out CNT_W: count of running cycles.
- `stall_cnt` out CNT_W: count of running cycles with any `stall_req` bit set.

## Operation
- **Debounce:**
  - `enter` and `mode_step` pass through 2-flop synchronisers.
  - The synchronised `enter` must hold a new level for DEB_CYCLES consecutive cycles to update the debounced level.
  - `press` is a registered 1-cycle pulse on each debounced 0→1 edge.
- **FSM:** states IDLE, RUN, STEP_WAIT, STEP_GO.
  - IDLE → RUN on `press` with `mode_step`=0; IDLE → STEP_WAIT on `press` with `mode_step`=1.
  - RUN → STEP_WAIT when `mode_step`=1.
  - STEP_WAIT → STEP_GO on `press` with `mode_step`=1; STEP_WAIT → RUN on `press` with `mode_step`=0.
  - STEP_GO → STEP_WAIT unconditionally, so exactly one running cycle per press.
  - `rst` returns the FSM to IDLE from any state, mid-operation included.
- **Not running** (IDLE, STEP_WAIT):
  - `stall` is all ones and `flush` is all zeros.
  - Requests are ignored and counters hold.
- **Running** (RUN, STEP_GO), resolved combinationally:
  - Let s = highest i with `stall_req[i]`. Then `stall[k]`=1 for all k≤s.
  - If s+1<NSTAGE, `flush[s+1]`=1 (bubble below the stalled stage).
  - A flush request `flush_req[i]` is accepted only if i>s. Let f = highest accepted i.
  - For every k<f: `flush[k]`=1 and `stall[k]`=0; flush overrides stall on younger stages.
  - A flush request at i≤s is ignored this cycle; the requester holds it.
  - `flush[0]` arises only from an accepted flush; a stall never bubbles stage 0.
- **Counters:**
  - `cyc_cnt` increments each running cycle.
  - `stall_cnt` increments each running cycle in which `|stall_req` is true.
  - Both wrap modulo 2^CNT_W and hold when not running.

## Timing
- Reset values: state IDLE, `stall`=all ones, `flush`=0, `running`=0, `cyc_cnt`=0, `stall_cnt`=0, debounced level 0, synchronisers 0.
- Press latency: `enter` rises and stays high. The synchroniser output goes high 2 edges later; after DEB_CYCLES further stable cycles the debounced level rises; `press` is high for the following single cycle.
- The FSM changes state at the edge ending the `press` cycle. `stall` drops in the next cycle.
- A bounce shorter than DEB_CYCLES restarts the stability count and produces no press.
- Holding `enter` produces one press only. The release must also debounce before another press is possible.
- `stall` and `flush` respond combinationally to `stall_req`/`flush_req` in the same cycle. There is no added latency.
- A `mode_step` change in RUN takes effect 3 edges after the input changes (2 synchroniser edges plus 1 FSM edge).

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, STEP_WAIT, STEP_GO);
  - default values for NSTAGE, DEB_CYCLES and CNT_W;
  - a sim-friendly constant DEB_CYCLES_SIM = 4.
- One sub-module, `btn_debounce` (synchroniser, stability counter, edge pulse), parametrised by DEB_CYCLES. It is reused for other board buttons.
- The stall/flush resolver is a combinational priority scan inside `pipe_ctrl`. It is not a separate module.

## Test plan
Directed scenarios, all with DEB_CYCLES=4 and NSTAGE=5:
1. Reset release with `enter` low: `stall`=5'b11111 and `running`=0 for 100 cycles, and counters stay 0.
2. `enter` high and held: `press` pulses once, 7 cycles after the first sampling edge. `running`=1 from the cycle after; later bounces of 2 cycles produce no second press.
3. RUN with `stall_req`=5'b00100: `stall`=5'b00111, `flush`=5'b01000, and `stall_cnt` increments.
4. RUN with `stall_req`=5'b00010 and `flush_req`=5'b01000: `flush`=5'b00111 and `stall`=0. With `flush_req`=5'b00001 and `stall_req`=5'b00010 instead, the flush is ignored: `flush`=5'b00100 and `stall`=5'b00011.
5. `mode_step`=1 then three presses: exactly 3 running cycles, and `cyc_cnt` advances by exactly 3.
6. `rst` asserted asynchronously in RUN, mid-cycle: `stall`=all ones immediately, the state returns to IDLE, and counters clear.
